ejc_priority_encoder: RTL and testbench

- Registered priority encoder. Converts a WIDTH-bit request vector into the BCD index (0-9) of the highest-numbered asserted bit.
- Gs flags that at least one input is asserted.
- Eo supports cascading, in the 74148 style.
- Used as a decimal/line-to-BCD front end feeding display and decode logic.

---
 rtl/ejc_priority_encoder.sv | 57 +++++
 tb/tb_ejc_priority_encoder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ejc_priority_encoder.sv
// Registered priority encoder: highest asserted request line -> BCD index,
// with 74148-style group-select (Gs) and enable-out (Eo) for cascading.
module ejc_priority_encoder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Ei,
    input  logic [WIDTH-1:0] D,
    output logic [3:0]       BCD,
    output logic             Gs,
    output logic             Eo
);

    // The index must fit one BCD digit; anything else is a build error.
    generate
        if (WIDTH < 2 || WIDTH > 10) begin : g_bad_width
            $error("ejc_priority_encoder: WIDTH must be in 2..10");
        end
    endgenerate

    logic [3:0] bcd_next;
    logic       gs_next;
    logic       eo_next;

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        bcd_next = 4'd0;
        gs_next  = 1'b0;
        eo_next  = 1'b0;
        if (Ei) begin
            // Ascending scan: the last hit wins, giving the highest index.
            for (int k = 0; k < WIDTH; k++) begin
                if (D[k]) begin
                    bcd_next = 4'(k);
                    gs_next  = 1'b1;
                end
            end
            eo_next = ~gs_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            BCD <= 4'd0;
            Gs  <= 1'b0;
            Eo  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all three outputs sampling
            // the same pre-edge values.
            BCD <= bcd_next;
            Gs  <= gs_next;
            Eo  <= eo_next;
        end
    end

endmodule

// File: tb/tb_ejc_priority_encoder.sv
// Scoreboard bench for ejc_priority_encoder (WIDTH=8): driver queues the
// hand-computed expectation, monitor compares one edge later.
module tb_ejc_priority_encoder;

    typedef struct {
        logic [7:0] d;
        logic [3:0] bcd;
        logic       gs;
        logic       eo;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       Ei;
    logic [7:0] D;
    logic [3:0] BCD;
    logic       Gs;
    logic       Eo;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    ejc_priority_encoder #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .Ei      (Ei),
        .D       (D),
        .BCD     (BCD),
        .Gs      (Gs),
        .Eo      (Eo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one vector just after a falling edge and queue what it must produce.
    task automatic apply(input logic [7:0] d, input logic ei,
                         input logic [3:0] bcd, input logic gs, input logic eo);
        exp_t e;
        @(negedge clk);
        D  = d;
        Ei = ei;
        e.d = d; e.bcd = bcd; e.gs = gs; e.eo = eo;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d results still pending after %0d edges", exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    // Monitor: results sampled 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("bcd d=%02h", e.d), BCD, e.bcd);
                check($sformatf("gs d=%02h", e.d), {3'b0, Gs}, {3'b0, e.gs});
                check($sformatf("eo d=%02h", e.d), {3'b0, Eo}, {3'b0, e.eo});
            end
        end
    end

    int sweep_bcd[8] = '{0, 0, 1, 1, 2, 2, 2, 2};

    initial begin
        exp_t e;
        reset_n = 1'b0;
        Ei      = 1'b1;
        D       = 8'hFF;
        #3;
        check("reset bcd", BCD, 4'd0);
        check("reset gs", {3'b0, Gs}, 4'd0);
        check("reset eo", {3'b0, Eo}, 4'd0);

        // Release with D=FF still applied: first edge encodes 7.
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        e.d = 8'hFF; e.bcd = 4'd7; e.gs = 1'b1; e.eo = 1'b0;
        exp_q.push_back(e);
        drain();

        // Binary sweep, back-to-back vectors.
        for (int i = 0; i < 8; i++)
            apply(8'(i), 1'b1, 4'(sweep_bcd[i]), (i != 0), (i == 0));
        drain();

        // One-hot walk.
        for (int k = 0; k < 8; k++)
            apply(8'(1 << k), 1'b1, 4'(k), 1'b1, 1'b0);
        drain();

        // Multiple asserted bits.
        apply(8'b1010_0110, 1'b1, 4'd7, 1'b1, 1'b0);
        apply(8'b0001_1111, 1'b1, 4'd4, 1'b1, 1'b0);
        apply(8'h80,        1'b1, 4'd7, 1'b1, 1'b0);
        apply(8'hFF,        1'b1, 4'd7, 1'b1, 1'b0);
        apply(8'h0C,        1'b1, 4'd3, 1'b1, 1'b0);
        drain();

        // Enable gating.
        apply(8'h40, 1'b0, 4'd0, 1'b0, 1'b0);
        apply(8'h00, 1'b0, 4'd0, 1'b0, 1'b0);
        apply(8'h40, 1'b1, 4'd6, 1'b1, 1'b0);
        apply(8'h00, 1'b1, 4'd0, 1'b0, 1'b1);
        apply(8'h20, 1'b1, 4'd5, 1'b1, 1'b0);
        drain();

        // Async reset pulse between edges while outputs are non-zero.
        #2;
        reset_n = 1'b0;
        #1;
        check("async bcd", BCD, 4'd0);
        check("async gs", {3'b0, Gs}, 4'd0);
        check("async eo", {3'b0, Eo}, 4'd0);
        @(negedge clk);
        reset_n = 1'b1;
        D  = 8'h08;
        Ei = 1'b1;
        e.d = 8'h08; e.bcd = 4'd3; e.gs = 1'b1; e.eo = 1'b0;
        exp_q.push_back(e);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
